// File: rtl/mmu_pkg.sv
// mmu_pkg: shared types and constants for the MMU/TLB slice.
//   mmu_state_t  - walker FSM states
//   PTE_V/W/R    - bit positions of the valid/write/read flags in a PTE
//   tlb_entry_t  - one TLB entry; page-number fields are sized for the widest
//                  supported address, so narrower configurations zero-extend
//   perm_fault() - load/store permission check against R/W flags
package mmu_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PTW_REQ  = 2'd1,
        PTW_WAIT = 2'd2
    } mmu_state_t;

    localparam int PTE_V = 0;
    localparam int PTE_W = 1;
    localparam int PTE_R = 2;

    localparam int TLB_PN_MAX_W = 32;

    typedef struct packed {
        logic                    valid;
        logic [TLB_PN_MAX_W-1:0] vpn;
        logic [TLB_PN_MAX_W-1:0] ppn;
        logic                    r;
        logic                    w;
    } tlb_entry_t;

    // A store needs W, a load needs R.
    function automatic logic perm_fault(input logic is_write, input logic r, input logic w);
        return (is_write && !w) || (!is_write && !r);
    endfunction

endpackage

// File: rtl/tlb_cam.sv
// tlb_cam: fully associative TLB storage.
//   clk, rst          - clock, synchronous active-high reset (clears all entries, pointer = 0)
//   flush             - invalidate every entry on this edge; fill pointer is kept
//   lookup_vpn        - combinational lookup key
//   hit/hit_ppn/hit_r/hit_w - lookup result
//   fill, fill_*      - write a new entry at the round-robin pointer, then advance it
module tlb_cam
    import mmu_pkg::*;
#(
    parameter int VPN_W   = 20,
    parameter int PPN_W   = 20,
    parameter int ENTRIES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [VPN_W-1:0] lookup_vpn,
    output logic             hit,
    output logic [PPN_W-1:0] hit_ppn,
    output logic             hit_r,
    output logic             hit_w,
    input  logic             fill,
    input  logic [VPN_W-1:0] fill_vpn,
    input  logic [PPN_W-1:0] fill_ppn,
    input  logic             fill_r,
    input  logic             fill_w
);

    localparam int PTR_W = $clog2(ENTRIES);

    tlb_entry_t              entries_r [ENTRIES];
    logic [PTR_W-1:0]        ptr_r;
    logic [ENTRIES-1:0]      match_s;
    logic [TLB_PN_MAX_W-1:0] ppn_s;
    logic                    r_s;
    logic                    w_s;

    // Parallel VPN compare; at most one entry can match, so the fields are OR-merged.
    always_comb begin
        match_s = {ENTRIES{1'b0}};
        ppn_s   = {TLB_PN_MAX_W{1'b0}};
        r_s     = 1'b0;
        w_s     = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            match_s[i] = entries_r[i].valid &&
                         (entries_r[i].vpn == TLB_PN_MAX_W'(lookup_vpn));
            ppn_s = ppn_s | (entries_r[i].ppn & {TLB_PN_MAX_W{match_s[i]}});
            r_s   = r_s | (entries_r[i].r & match_s[i]);
            w_s   = w_s | (entries_r[i].w & match_s[i]);
        end
    end

    assign hit     = |match_s;
    assign hit_ppn = PPN_W'(ppn_s);
    assign hit_r   = r_s;
    assign hit_w   = w_s;

    // Entry storage: flush beats a same-cycle fill so a flushed walk never lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_r[i] <= '0;
            end
            ptr_r <= {PTR_W{1'b0}};
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_r[i].valid <= 1'b0;
            end
        end else if (fill) begin
            entries_r[ptr_r] <= {1'b1, TLB_PN_MAX_W'(fill_vpn), TLB_PN_MAX_W'(fill_ppn),
                                 fill_r, fill_w};
            ptr_r            <= ptr_r + PTR_W'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/mmu_tlb.sv
// mmu_tlb: MMU with fully associative TLB and single-level page-table walker.
//   clk, rst                       - clock, synchronous active-high reset
//   req_valid/req_ready/req_vaddr/req_write - translation request
//   resp_valid/resp_paddr/resp_fault        - one-cycle registered response
//   ptbase                         - page-table base, used when a walk starts
//   flush                          - invalidate the TLB
//   ptw_req_valid/ptw_req_addr/ptw_req_ready - walker PTE read request
//   ptw_resp_valid/ptw_resp_data   - returned PTE
module mmu_tlb
    import mmu_pkg::*;
#(
    parameter int VA_W        = 32,
    parameter int PA_W        = 32,
    parameter int PAGE_BITS   = 12,
    parameter int TLB_ENTRIES = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [VA_W-1:0] req_vaddr,
    input  logic            req_write,
    output logic            resp_valid,
    output logic [PA_W-1:0] resp_paddr,
    output logic            resp_fault,
    input  logic [PA_W-1:0] ptbase,
    input  logic            flush,
    output logic            ptw_req_valid,
    output logic [PA_W-1:0] ptw_req_addr,
    input  logic            ptw_req_ready,
    input  logic            ptw_resp_valid,
    input  logic [31:0]     ptw_resp_data
);

    localparam int VPN_W = VA_W - PAGE_BITS;
    localparam int PPN_W = PA_W - PAGE_BITS;

    mmu_state_t           state_r;
    logic [VPN_W-1:0]     vpn_r;
    logic [PAGE_BITS-1:0] off_r;
    logic                 write_r;
    logic                 flush_pend_r;
    logic                 resp_valid_r;
    logic [PA_W-1:0]      resp_paddr_r;
    logic                 resp_fault_r;
    logic                 ptw_req_valid_r;
    logic [PA_W-1:0]      ptw_req_addr_r;

    logic [VPN_W-1:0]     req_vpn_s;
    logic [PAGE_BITS-1:0] req_off_s;
    logic [PA_W-1:0]      pte_addr_s;
    logic                 req_ready_s;
    logic                 accept_s;
    logic                 hit_s;
    logic [PPN_W-1:0]     hit_ppn_s;
    logic                 hit_r_s;
    logic                 hit_w_s;
    logic                 hit_fault_s;
    logic [PPN_W-1:0]     pte_ppn_s;
    logic                 pte_v_s;
    logic                 pte_r_s;
    logic                 pte_w_s;
    logic                 walk_fault_s;
    logic                 fill_s;

    assign req_vpn_s  = VPN_W'(req_vaddr >> PAGE_BITS);
    assign req_off_s  = req_vaddr[PAGE_BITS-1:0];
    // Wrap-around of the table address is intentional.
    assign pte_addr_s = ptbase + PA_W'({req_vpn_s, 2'b00});

    assign req_ready_s = (state_r == IDLE) && !flush && !rst;
    assign accept_s    = req_valid && req_ready_s;
    assign hit_fault_s = perm_fault(req_write, hit_r_s, hit_w_s);

    assign pte_ppn_s    = PPN_W'(ptw_resp_data >> PAGE_BITS);
    assign pte_v_s      = ptw_resp_data[PTE_V];
    assign pte_r_s      = ptw_resp_data[PTE_R];
    assign pte_w_s      = ptw_resp_data[PTE_W];
    assign walk_fault_s = !pte_v_s || perm_fault(write_r, pte_r_s, pte_w_s);
    // Permission faults still fill; a flush seen during the walk cancels the fill.
    assign fill_s       = (state_r == PTW_WAIT) && ptw_resp_valid && pte_v_s && !flush_pend_r;

    tlb_cam #(
        .VPN_W   (VPN_W),
        .PPN_W   (PPN_W),
        .ENTRIES (TLB_ENTRIES)
    ) u_cam (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .lookup_vpn (req_vpn_s),
        .hit        (hit_s),
        .hit_ppn    (hit_ppn_s),
        .hit_r      (hit_r_s),
        .hit_w      (hit_w_s),
        .fill       (fill_s),
        .fill_vpn   (vpn_r),
        .fill_ppn   (pte_ppn_s),
        .fill_r     (pte_r_s),
        .fill_w     (pte_w_s)
    );

    // Walker FSM and registered response/walker outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            vpn_r           <= {VPN_W{1'b0}};
            off_r           <= {PAGE_BITS{1'b0}};
            write_r         <= 1'b0;
            flush_pend_r    <= 1'b0;
            resp_valid_r    <= 1'b0;
            resp_paddr_r    <= {PA_W{1'b0}};
            resp_fault_r    <= 1'b0;
            ptw_req_valid_r <= 1'b0;
            ptw_req_addr_r  <= {PA_W{1'b0}};
        end else begin
            resp_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    flush_pend_r <= 1'b0;
                    if (accept_s && hit_s) begin
                        resp_valid_r <= 1'b1;
                        resp_fault_r <= hit_fault_s;
                        resp_paddr_r <= hit_fault_s ? {PA_W{1'b0}} : {hit_ppn_s, req_off_s};
                    end else if (accept_s) begin
                        vpn_r           <= req_vpn_s;
                        off_r           <= req_off_s;
                        write_r         <= req_write;
                        ptw_req_valid_r <= 1'b1;
                        ptw_req_addr_r  <= pte_addr_s;
                        state_r         <= PTW_REQ;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                PTW_REQ: begin
                    flush_pend_r <= flush_pend_r | flush;
                    if (ptw_req_ready) begin
                        ptw_req_valid_r <= 1'b0;
                        state_r         <= PTW_WAIT;
                    end else begin
                        state_r <= PTW_REQ;
                    end
                end
                PTW_WAIT: begin
                    flush_pend_r <= flush_pend_r | flush;
                    if (ptw_resp_valid) begin
                        resp_valid_r <= 1'b1;
                        resp_fault_r <= walk_fault_s;
                        resp_paddr_r <= walk_fault_s ? {PA_W{1'b0}} : {pte_ppn_s, off_r};
                        state_r      <= IDLE;
                    end else begin
                        state_r <= PTW_WAIT;
                    end
                end
                default: begin
                    ptw_req_valid_r <= 1'b0;
                    state_r         <= IDLE;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_s;
    assign resp_valid    = resp_valid_r;
    assign resp_paddr    = resp_paddr_r;
    assign resp_fault    = resp_fault_r;
    assign ptw_req_valid = ptw_req_valid_r;
    assign ptw_req_addr  = ptw_req_addr_r;

endmodule

// File: tb/tb_mmu_tlb.sv
// tb_mmu_tlb: scoreboard bench for mmu_tlb with a zero-wait page-table memory model.
module tb_mmu_tlb;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_vaddr;
    logic        req_write;
    logic        resp_valid;
    logic [31:0] resp_paddr;
    logic        resp_fault;
    logic [31:0] ptbase;
    logic        flush;
    logic        flush_tb;
    logic        flush_w;
    logic        ptw_req_valid;
    logic [31:0] ptw_req_addr;
    logic        ptw_req_ready;
    logic        ptw_resp_valid;
    logic [31:0] ptw_resp_data;

    typedef struct {
        logic [31:0] pa;
        logic        f;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          walk_cnt = 0;
    int          last_resp_cyc = 0;
    logic [31:0] last_ptw_addr = 32'h0;
    logic [31:0] pte_next = 32'h0;
    logic        flush_in_wait = 1'b0;

    assign flush = flush_tb | flush_w;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mmu_tlb #(
        .VA_W        (32),
        .PA_W        (32),
        .PAGE_BITS   (12),
        .TLB_ENTRIES (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_vaddr      (req_vaddr),
        .req_write      (req_write),
        .resp_valid     (resp_valid),
        .resp_paddr     (resp_paddr),
        .resp_fault     (resp_fault),
        .ptbase         (ptbase),
        .flush          (flush),
        .ptw_req_valid  (ptw_req_valid),
        .ptw_req_addr   (ptw_req_addr),
        .ptw_req_ready  (ptw_req_ready),
        .ptw_resp_valid (ptw_resp_valid),
        .ptw_resp_data  (ptw_resp_data)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every response pops one expectation.
    always @(negedge clk) begin
        if (resp_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_resp: got resp_valid=1 paddr 0x%08h, expected no response",
                         resp_paddr);
            end else begin
                mon_e = sb_q.pop_front();
                check("resp_paddr", resp_paddr, mon_e.pa);
                check("resp_fault", {31'd0, resp_fault}, {31'd0, mon_e.f});
                last_resp_cyc = cyc;
            end
        end
    end

    // Page-table memory: accepts at once, returns the PTE one cycle later
    // (optionally pulsing flush while the walker waits).
    always @(negedge clk) begin
        if (ptw_req_valid && ptw_req_ready && !rst) begin
            walk_cnt++;
            last_ptw_addr = ptw_req_addr;
            @(posedge clk);
            #1;
            if (flush_in_wait) begin
                flush_w = 1'b1;
                @(posedge clk);
                #1;
                flush_w = 1'b0;
            end
            ptw_resp_valid = 1'b1;
            ptw_resp_data  = pte_next;
            @(posedge clk);
            #1;
            ptw_resp_valid = 1'b0;
        end
    end

    task automatic access(input logic [31:0] va, input logic wr, input logic [31:0] pte,
                          input int exp_walk, input logic [31:0] exp_pa, input logic exp_f,
                          input logic [31:0] exp_ptw, input int exp_lat);
        int w0;
        int acc_cyc;
        bit got;
        pte_next = pte;
        w0 = walk_cnt;
        sb_q.push_back('{pa: exp_pa, f: exp_f});
        @(negedge clk);
        req_valid = 1'b1;
        req_vaddr = va;
        req_write = wr;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (req_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: va 0x%08h never accepted, expected accept", va);
            req_valid = 1'b0;
            sb_q.delete();
            return;
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            #2;
            if (sb_q.size() == 0) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL resp_timeout: va 0x%08h got no response, expected one", va);
            sb_q.delete();
        end else begin
            check("latency", last_resp_cyc - acc_cyc + 1, exp_lat);
        end
        check("walk_count", walk_cnt - w0, exp_walk);
        if (exp_walk != 0) check("ptw_req_addr", last_ptw_addr, exp_ptw);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        req_valid      = 1'b0;
        req_vaddr      = 32'h0;
        req_write      = 1'b0;
        flush_tb       = 1'b0;
        flush_w        = 1'b0;
        ptbase         = 32'h8000_0000;
        ptw_req_ready  = 1'b1;
        ptw_resp_valid = 1'b0;
        ptw_resp_data  = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_paddr", resp_paddr, 32'h0);
        check("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
        check("rst_ptw_req_valid", {31'd0, ptw_req_valid}, 32'd0);
        check("rst_ptw_req_addr", ptw_req_addr, 32'h0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // miss, then hit on the same page
        access(32'h0000_100A, 1'b0, 32'h0002_3007, 1, 32'h0002_300A, 1'b0, 32'h8000_0004, 3);
        access(32'h0000_1FFC, 1'b0, 32'h0, 0, 32'h0002_3FFC, 1'b0, 32'h0, 1);
        // write-permission fault still fills; following read hits
        access(32'h0000_2000, 1'b1, 32'h0004_5005, 1, 32'h0, 1'b1, 32'h8000_0008, 3);
        access(32'h0000_2010, 1'b0, 32'h0, 0, 32'h0004_5010, 1'b0, 32'h0, 1);
        // invalid PTE: fault and no fill, so the repeat walks again
        access(32'h0000_3000, 1'b0, 32'h0, 1, 32'h0, 1'b1, 32'h8000_000C, 3);
        access(32'h0000_3000, 1'b0, 32'h0, 1, 32'h0, 1'b1, 32'h8000_000C, 3);
        // pages 3..9 complete nine fills; page 1 is the victim
        for (int p = 3; p <= 9; p++) begin
            access(32'(p) << 12, 1'b0, ((32'h100 + 32'(p)) << 12) | 32'h7, 1,
                   (32'h100 + 32'(p)) << 12, 1'b0, 32'h8000_0000 + 32'(p) * 4, 3);
        end
        access(32'h0000_1000, 1'b0, 32'h0002_3007, 1, 32'h0002_3000, 1'b0, 32'h8000_0004, 3);
        access(32'h0000_9000, 1'b0, 32'h0, 0, 32'h0010_9000, 1'b0, 32'h0, 1);

        // flush in IDLE blocks the request port for that cycle
        @(negedge clk);
        flush_tb = 1'b1;
        #1;
        check("ready_during_flush", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        flush_tb = 1'b0;
        access(32'h0000_2000, 1'b0, 32'h0004_5005, 1, 32'h0004_5000, 1'b0, 32'h8000_0008, 3);

        // flush while waiting for the PTE: response delivered, fill dropped
        flush_in_wait = 1'b1;
        access(32'h0000_4123, 1'b0, 32'h0010_4007, 1, 32'h0010_4123, 1'b0, 32'h8000_0010, 4);
        flush_in_wait = 1'b0;
        access(32'h0000_4123, 1'b0, 32'h0010_4007, 1, 32'h0010_4123, 1'b0, 32'h8000_0010, 3);

        // reset while the walker request is stalled
        ptw_req_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_vaddr = 32'h0000_5000;
        req_write = 1'b0;
        #1;
        check("ready_before_miss", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("ready_during_walk", {31'd0, req_ready}, 32'd0);
        check("ptw_req_valid_stalled", {31'd0, ptw_req_valid}, 32'd1);
        @(negedge clk);
        #1;
        check("ptw_req_addr_held", ptw_req_addr, 32'h8000_0014);
        rst = 1'b1;
        #1;
        check("ready_in_rst", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        #1;
        check("ptw_req_valid_after_rst", {31'd0, ptw_req_valid}, 32'd0);
        check("resp_valid_after_rst", {31'd0, resp_valid}, 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst2", {31'd0, req_ready}, 32'd1);
        ptw_req_ready = 1'b1;
        repeat (3) @(negedge clk);
        // TLB was cleared by reset: page 4 walks, then hits
        access(32'h0000_4000, 1'b0, 32'h0010_4007, 1, 32'h0010_4000, 1'b0, 32'h8000_0010, 3);
        access(32'h0000_4004, 1'b1, 32'h0, 0, 32'h0010_4004, 1'b0, 32'h0, 1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
